// File: rtl/serial_display_rx.sv
// -----------------------------------------------------------------------------
// serial_display_rx
//
// Receives the display link from the clock core (serial data, shift clock and
// latch strobe). The receiver oversamples all three lines in the i_clk domain,
// shifts in frames of SHIFT_WIDTH bits and publishes a parallel word when a
// latch arrives after exactly SHIFT_WIDTH shift edges.
//
// Ports
//   i_clk            system clock; all logic runs on its rising edge
//   i_reset          synchronous active-high reset
//   i_serial_data    serial data line (asynchronous)
//   i_serial_clk     shift clock (asynchronous); data taken on its rising edge
//   i_serial_latch   latch strobe (asynchronous); frame ends on its rising edge
//   o_parallel_data  last valid frame; the first bit shifted sits in the MSB
//   o_data_valid     one-cycle pulse when o_parallel_data updates
//   o_frame_error    one-cycle pulse on a latch with the wrong bit count
//   o_error_count    saturating count of frame errors
// -----------------------------------------------------------------------------
module serial_display_rx #(
    parameter int SHIFT_WIDTH = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_serial_data,
    input  logic                   i_serial_clk,
    input  logic                   i_serial_latch,
    output logic [SHIFT_WIDTH-1:0] o_parallel_data,
    output logic                   o_data_valid,
    output logic                   o_frame_error,
    output logic [7:0]             o_error_count
);

    localparam int                CNT_W     = $clog2(SHIFT_WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(SHIFT_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(SHIFT_WIDTH + 1);
    localparam logic [2:0]        WARM_LAST = 3'(SYNC_STAGES);

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               warm_cnt_q, warm_cnt_d;

    logic [SYNC_STAGES-1:0]   data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]   latch_sync_q, latch_sync_d;
    logic                     sclk_prev_q, sclk_prev_d;
    logic                     latch_prev_q, latch_prev_d;
    logic [SHIFT_WIDTH-1:0]   shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SHIFT_WIDTH-1:0]   parallel_q, parallel_d;
    logic                     valid_q, valid_d;
    logic                     error_q, error_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    logic                     shift_edge;
    logic                     latch_edge;
    logic [SHIFT_WIDTH-1:0]   shift_eff;
    logic [CNT_W-1:0]         cnt_eff;

    // Warm-up FSM state register. After reset the synchronizers are refilling
    // from zero, so a line already high would look like a fresh rising edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WARMUP;
            warm_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Stay in WARMUP for SYNC_STAGES+1 cycles, which is long enough for the
    // synchronizer and the prev flop to both hold the real line level.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        case (state_q)
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 3'd1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = WARMUP;
        endcase
    end

    // Datapath registers: synchronizers, edge history, shifter and outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_sync_q  <= '0;
            sclk_sync_q  <= '0;
            latch_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            latch_prev_q <= 1'b0;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            parallel_q   <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            data_sync_q  <= data_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            latch_sync_q <= latch_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            latch_prev_q <= latch_prev_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            parallel_q   <= parallel_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // The three chains have equal depth so data stays aligned with its clock.
    // A shift and a latch in the same cycle are resolved by computing the
    // post-shift value and count first and letting the latch judge those.
    always_comb begin
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
        sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
        latch_prev_d = latch_sync_q[SYNC_STAGES-1];

        shift_edge = (state_q == RUN) && sclk_sync_q[SYNC_STAGES-1] && !sclk_prev_q;
        latch_edge = (state_q == RUN) && latch_sync_q[SYNC_STAGES-1] && !latch_prev_q;

        shift_eff = shift_reg_q;
        cnt_eff   = bit_cnt_q;
        if (shift_edge) begin
            shift_eff = {shift_reg_q[SHIFT_WIDTH-2:0], data_sync_q[SYNC_STAGES-1]};
            if (bit_cnt_q != CNT_SAT) begin
                cnt_eff = bit_cnt_q + CNT_W'(1);
            end
        end

        shift_reg_d = shift_eff;
        bit_cnt_d   = cnt_eff;
        parallel_d  = parallel_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (latch_edge) begin
            bit_cnt_d = '0;
            if (cnt_eff == CNT_FULL) begin
                parallel_d = shift_eff;
                valid_d    = 1'b1;
            end else begin
                error_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign o_parallel_data = parallel_q;
    assign o_data_valid    = valid_q;
    assign o_frame_error   = error_q;
    assign o_error_count   = err_cnt_q;

endmodule

// File: tb/tb_serial_display_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_display_rx
//
// Drives the display link with directed frames and compares the receiver
// against a frame-level model: bits sampled on shift-clock rises are kept in a
// queue, a latch rise turns the queue into a word or an error, and the result
// appears on the outputs SYNC_STAGES cycles after the latch is first sampled.
// -----------------------------------------------------------------------------
module tb_serial_display_rx;

    localparam int SW = 48;
    localparam int S  = 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_serial_data = 1'b0;
    logic          i_serial_clk = 1'b0;
    logic          i_serial_latch = 1'b0;
    logic [SW-1:0] o_parallel_data;
    logic          o_data_valid;
    logic          o_frame_error;
    logic [7:0]    o_error_count;

    serial_display_rx #(.SHIFT_WIDTH(SW), .SYNC_STAGES(S)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_serial_data   (i_serial_data),
        .i_serial_clk    (i_serial_clk),
        .i_serial_latch  (i_serial_latch),
        .o_parallel_data (o_parallel_data),
        .o_data_valid    (o_data_valid),
        .o_frame_error   (o_frame_error),
        .o_error_count   (o_error_count)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Compare one observed value with its expectation and keep the tallies.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level reference model, advanced on every rising i_clk edge.
    typedef struct packed {
        logic          valid;
        logic          err;
        logic [SW-1:0] data;
        logic [7:0]    cnt;
    } snap_t;

    snap_t    pipe [0:S];
    bit       bits [$];
    logic [SW-1:0] m_data = '0;
    int       m_cnt = 0;
    logic     prev_sclk = 1'b0;
    logic     prev_latch = 1'b0;
    int       since_reset = 0;
    bit       model_ok = 1'b0;

    always @(posedge i_clk) begin
        snap_t s;
        logic  s_rise, l_rise, live;
        logic [SW-1:0] v;
        if (i_reset) begin
            bits.delete();
            m_data      = '0;
            m_cnt       = 0;
            prev_sclk   = 1'b0;
            prev_latch  = 1'b0;
            since_reset = 0;
            model_ok    = 1'b1;
            for (int i = 0; i <= S; i++) pipe[i] = '0;
        end else begin
            s_rise     = i_serial_clk && !prev_sclk;
            l_rise     = i_serial_latch && !prev_latch;
            prev_sclk  = i_serial_clk;
            prev_latch = i_serial_latch;
            if (since_reset < 1000) since_reset++;
            // Edges first sampled in the two cycles after reset are swallowed
            // by the warm-up window.
            live = (since_reset >= 2);
            s.valid = 1'b0;
            s.err   = 1'b0;
            if (live && s_rise) bits.push_back(i_serial_data);
            if (live && l_rise) begin
                if (bits.size() == SW) begin
                    v = '0;
                    foreach (bits[i]) v[SW-1-i] = bits[i];
                    m_data  = v;
                    s.valid = 1'b1;
                end else begin
                    s.err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                bits.delete();
            end
            s.data = m_data;
            s.cnt  = 8'(m_cnt);
            for (int i = S; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = s;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (model_ok) begin
            checkOutput("cyc_data",  64'(o_parallel_data), 64'(pipe[S].data));
            checkOutput("cyc_valid", 64'(o_data_valid),    64'(pipe[S].valid));
            checkOutput("cyc_error", 64'(o_frame_error),   64'(pipe[S].err));
            checkOutput("cyc_count", 64'(o_error_count),   64'(pipe[S].cnt));
        end
    end

    // Pulse tallies and captured words used by the literal checks.
    int            valid_pulses = 0;
    int            err_pulses = 0;
    logic [SW-1:0] cap [$];

    always @(negedge i_clk) begin
        if (o_data_valid) begin
            valid_pulses++;
            cap.push_back(o_parallel_data);
        end
        if (o_frame_error) err_pulses++;
    end

    // Shift out the low n bits of v, most significant first.
    task automatic applyStimulus(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            i_serial_data = v[i];
            @(negedge i_clk);
            i_serial_clk = 1'b1;
            repeat (2) @(negedge i_clk);
            i_serial_clk = 1'b0;
            @(negedge i_clk);
        end
    endtask

    task automatic pulseLatch();
        i_serial_latch = 1'b1;
        repeat (2) @(negedge i_clk);
        i_serial_latch = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic settle();
        repeat (S + 3) @(negedge i_clk);
    endtask

    task automatic clearTally();
        valid_pulses = 0;
        err_pulses   = 0;
        cap.delete();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SW-1:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
        w_a = 48'h123456789ABC;
        w_b = 48'hFFFF00000001;
        w_c = 48'h5A5A0F0FC3C3;
        w_d = 48'hC3C30000BEEF;
        w_e = 48'hA5A5A5A5A5A5;
        w_f = 48'h0123456789AB;
        w_g = 48'hDEADBEEF0042;
        w_h = 48'h8000000000FF;

        // Reset state
        repeat (3) @(negedge i_clk);
        checkOutput("reset_data",  64'(o_parallel_data), 64'd0);
        checkOutput("reset_valid", 64'(o_data_valid),    64'd0);
        checkOutput("reset_error", 64'(o_frame_error),   64'd0);
        checkOutput("reset_count", 64'(o_error_count),   64'd0);
        i_reset = 1'b0;
        repeat (6) @(negedge i_clk);

        // Good frame
        clearTally();
        applyStimulus(64'(w_a), 48);
        pulseLatch();
        settle();
        checkOutput("good_data",   64'(o_parallel_data), 64'h123456789ABC);
        checkOutput("good_count",  64'(o_error_count),   64'd0);
        checkOutput("good_pulses", 64'(valid_pulses),    64'd1);
        checkOutput("good_errs",   64'(err_pulses),      64'd0);

        // Short frame, long frame, then recovery
        clearTally();
        applyStimulus(64'h0, 47);
        pulseLatch();
        settle();
        checkOutput("short_count", 64'(o_error_count),   64'd1);
        checkOutput("short_data",  64'(o_parallel_data), 64'h123456789ABC);
        checkOutput("short_errs",  64'(err_pulses),      64'd1);
        applyStimulus(64'h1FFFFFFFFFFFF, 49);
        pulseLatch();
        settle();
        checkOutput("long_count", 64'(o_error_count),   64'd2);
        checkOutput("long_data",  64'(o_parallel_data), 64'h123456789ABC);
        clearTally();
        applyStimulus(64'(w_b), 48);
        pulseLatch();
        settle();
        checkOutput("recover_data",   64'(o_parallel_data), 64'hFFFF00000001);
        checkOutput("recover_pulses", 64'(valid_pulses),    64'd1);

        // Coincident 48th shift edge and latch edge
        clearTally();
        applyStimulus(64'(w_c >> 1), 47);
        i_serial_data = w_c[0];
        @(negedge i_clk);
        i_serial_clk   = 1'b1;
        i_serial_latch = 1'b1;
        repeat (2) @(negedge i_clk);
        i_serial_clk   = 1'b0;
        i_serial_latch = 1'b0;
        repeat (2) @(negedge i_clk);
        settle();
        checkOutput("coinc_data",   64'(o_parallel_data), 64'h5A5A0F0FC3C3);
        checkOutput("coinc_pulses", 64'(valid_pulses),    64'd1);
        checkOutput("coinc_errs",   64'(err_pulses),      64'd0);
        applyStimulus(64'(w_d), 48);
        pulseLatch();
        settle();
        checkOutput("after_coinc_data", 64'(o_parallel_data), 64'hC3C30000BEEF);
        checkOutput("after_coinc_count", 64'(o_error_count),  64'd2);

        // Reset in the middle of a frame
        applyStimulus(64'hFACE5, 20);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checkOutput("midrst_data",  64'(o_parallel_data), 64'd0);
        checkOutput("midrst_count", 64'(o_error_count),   64'd0);
        repeat (6) @(negedge i_clk);
        clearTally();
        applyStimulus(64'(w_e), 48);
        pulseLatch();
        settle();
        checkOutput("postrst_data",  64'(o_parallel_data), 64'hA5A5A5A5A5A5);
        checkOutput("postrst_valid", 64'(valid_pulses),    64'd1);
        checkOutput("postrst_errs",  64'(err_pulses),      64'd0);

        // Latch and shift clock held high across reset release
        clearTally();
        i_reset        = 1'b1;
        i_serial_latch = 1'b1;
        i_serial_clk   = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        i_serial_latch = 1'b0;
        i_serial_clk   = 1'b0;
        settle();
        checkOutput("held_valid", 64'(valid_pulses),  64'd0);
        checkOutput("held_errs",  64'(err_pulses),    64'd0);
        checkOutput("held_count", 64'(o_error_count), 64'd0);

        // Error counter saturation
        applyStimulus(64'(w_f), 48);
        pulseLatch();
        settle();
        clearTally();
        for (int k = 0; k < 300; k++) pulseLatch();
        settle();
        checkOutput("sat_count", 64'(o_error_count),   64'd255);
        checkOutput("sat_errs",  64'(err_pulses),      64'd300);
        checkOutput("sat_data",  64'(o_parallel_data), 64'h0123456789AB);

        // Back-to-back frames, next shift edge two cycles after latch falls
        clearTally();
        applyStimulus(64'(w_g), 48);
        i_serial_latch = 1'b1;
        repeat (2) @(negedge i_clk);
        i_serial_latch = 1'b0;
        @(negedge i_clk);
        applyStimulus(64'(w_h), 48);
        pulseLatch();
        settle();
        checkOutput("b2b_pulses", 64'(valid_pulses), 64'd2);
        checkOutput("b2b_first",  64'((cap.size() > 0) ? cap[0] : '0), 64'hDEADBEEF0042);
        checkOutput("b2b_second", 64'((cap.size() > 1) ? cap[1] : '0), 64'h8000000000FF);
        checkOutput("b2b_count",  64'(o_error_count), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_display_rx.md
# serial_display_rx

Synthesizable receiver for the clock's serial display link (data, shift clock, latch). It oversamples the three link lines in the system clock domain and shifts in frames of SHIFT_WIDTH bits. On each latch it checks the frame length and publishes a validated parallel word. It sits at the far end of the link from the clock core's serial output, for board-level display drivers and for self-checking loopback.

## Interface

- SHIFT_WIDTH, 48: frame length in bits (6 digits × 8 segments).
- SYNC_STAGES, 2: synchronizer depth per input line; legal range is 2 to 4.
- i_clk  input  1: system clock (~50 MHz). All logic is on its rising edge.
- i_reset  input  1: synchronous, active-high reset.
- i_serial_data  input  1: serial data, asynchronous to i_clk.
- i_serial_clk  input  1: shift clock, asynchronous. Data is taken on its rising edge.
- i_serial_latch  input  1: latch strobe, asynchronous. A frame completes on its rising edge.
- o_parallel_data  output  SHIFT_WIDTH: last valid frame; the first bit shifted ends up in the MSB.
- o_data_valid  output  1: one-cycle pulse when o_parallel_data updates.
- o_frame_error  output  1: one-cycle pulse on a latch whose bit count is not SHIFT_WIDTH.
- o_error_count  output  8: saturating count of frame errors.

## Operation

- **Synchronizers.** Each input passes through SYNC_STAGES flops. All three chains have equal depth, so the synced data stays aligned with the synced clock.
- **Edge detection.** The last synchronizer stage is compared with a registered copy. A rising edge is defined as sync=1 and prev=0.
- **Shift-clock edge.**
  - shift_reg <= {shift_reg[SHIFT_WIDTH-2:0], synced_data}.
  - bit_cnt increments and saturates at SHIFT_WIDTH+1.
  - bit_cnt width is $clog2(SHIFT_WIDTH+2).
- **Latch edge.**
  - If the effective count equals SHIFT_WIDTH: o_parallel_data <= effective shift value, and o_data_valid=1 for one cycle.
  - Otherwise: o_frame_error=1 for one cycle, o_parallel_data is held, and o_error_count increments, saturating at 255.
  - bit_cnt clears to 0 in both cases. shift_reg is not cleared.
- **Simultaneous shift and latch edges (same cycle).** The shift is applied first. The latch evaluates the post-shift shift_reg and the post-increment count. bit_cnt ends at 0, not 1.
- **Warm-up state machine.** States are WARMUP and RUN.
  - Reset enters WARMUP with warm-up counter 0.
  - WARMUP lasts SYNC_STAGES+1 cycles after i_reset deasserts, then moves to RUN.
  - In WARMUP, edge detection is suppressed. The synchronizer and prev flops still update.
  - Effect: lines held high across reset release produce no spurious shift or latch event.
- **Reset (synchronous, mid-frame included).**
  - All synchronizer and prev flops, shift_reg, bit_cnt, o_parallel_data, o_data_valid, o_frame_error and o_error_count go to 0. State goes to WARMUP.
  - A partial frame is discarded.
- **Latch while i_serial_clk is high.** This is legal. Only edges matter, not levels.

## Timing

- **Latency.**
  - t0 is the first i_clk edge sampling i_serial_latch=1 (in RUN).
  - o_data_valid or o_frame_error is high in the cycle following edge t0+SYNC_STAGES.
  - o_parallel_data changes on the same edge and is stable from then on.
- **Shift-clock input constraint.** i_serial_clk high and low phases must each last at least 2 i_clk cycles.
- **Latch input constraint.** i_serial_latch high and low phases must each last at least 2 i_clk cycles.
- **Data setup/hold.** i_serial_data must be stable at least 1 i_clk cycle before and 1 cycle after the i_serial_clk rising edge. The default 50 MHz / 1 MHz link meets this.
- **Throughput.** Back-to-back frames are allowed. A shift edge in the cycle after a latch edge counts toward the next frame.
- **Output pulses.** The two pulses are mutually exclusive and never exceed one cycle.

## Test plan

- **Good frame.** Shift 0x123456789ABC MSB-first (48 edges), then latch. Expect o_parallel_data=0x123456789ABC, one o_data_valid pulse SYNC_STAGES cycles after the latch is sampled, o_frame_error=0 and o_error_count=0.
- **Short and long frames.**
  - Shift 47 bits, then latch: o_frame_error pulse, data unchanged, o_error_count=1.
  - Shift 49 bits, then latch: o_error_count=2.
  - Send a good frame of 0xFFFF00000001: o_data_valid and the new data.
- **Coincident edges.** The 48th i_serial_clk rise and the i_serial_latch rise arrive in the same i_clk cycle. Expect o_data_valid with all 48 bits correct. The next frame's count starts from 0.
- **Reset mid-frame.**
  - Assert i_reset for 1 cycle after 20 bits: all outputs read 0.
  - Send a full frame of 0xA5A5A5A5A5A5: valid, no error.
  - Hold i_serial_latch=1 across reset release: no pulse of either kind.
- **Error counter saturation.** Send 300 zero-bit latches. Expect o_error_count to stop at 255, o_frame_error to keep pulsing, and o_parallel_data to be unchanged.
- **Back-to-back frames.** Send two frames with the first shift edge 2 cycles after the latch falls. Expect two valid pulses and both values captured in order.
